// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle core controller: opcodes, FSM states,
// PC/writeback mux selects, trap causes and the decode legality check.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_MDR   = 2'b01;
    localparam logic [1:0] WB_SEL_LINK  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM   = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_R, OP_IMM, OP_JAL, OP_LUI, OP_AUIPC: bad = 1'b0;
            OP_LOAD:   bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OP_STORE:  bad = (f3 > 3'd2);
            OP_BRANCH: bad = (f3 == 3'd2) || (f3 == 3'd3);
            OP_JALR:   bad = (f3 != 3'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive memory-wait cycles; expired fires in the wait cycle that
// would bring the count to TIMEOUT. TIMEOUT of 0 never expires.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        expired = ENABLED && count_en && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && ENABLED && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing, mux
// selects, sticky trap on illegal instruction or memory timeout, retire count.
module core_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        rf_we,
    output logic        pc_write,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    input  logic        dbg_instret_wr,
    input  logic [31:0] dbg_instret_wdata,
    output ctrl_state_e dbg_state
);

    ctrl_state_e state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] instret_q, instret_d;
    logic        wait_en;
    logic        expired;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .count_en (wait_en),
        .clear    (~wait_en),
        .expired  (expired)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        wait_en   = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        mdr_write = 1'b0;
        rf_we     = 1'b0;
        pc_write  = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        wb_sel    = WB_SEL_ALU;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                wait_en  = ~imem_valid;
                // A handshake in the expiry cycle still wins over the timeout.
                if (imem_valid) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM;
                end
            end
            ST_DECODE: begin
                if (is_illegal(opcode, funct3)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a_sel = (opcode == OP_AUIPC);
                alu_b_sel = (opcode != OP_R) && (opcode != OP_BRANCH);
                if (opcode == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                    state_d  = ST_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                wait_en  = ~dmem_ready;
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        mdr_write = 1'b1;
                        state_d   = ST_WB;
                    end
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                state_d  = ST_FETCH;
                case (opcode)
                    OP_JAL:  begin pc_sel = PC_SEL_IMM;  wb_sel = WB_SEL_LINK; end
                    OP_JALR: begin pc_sel = PC_SEL_JALR; wb_sel = WB_SEL_LINK; end
                    OP_LOAD: wb_sel = WB_SEL_MDR;
                    OP_LUI:  wb_sel = WB_SEL_IMM;
                    default: wb_sel = WB_SEL_ALU;
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase

        // Reset held low suppresses every strobe so an aborted instruction
        // cannot leak a final write or memory request.
        if (!reset_n) begin
            wait_en   = 1'b0;
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            ir_write  = 1'b0;
            mdr_write = 1'b0;
            rf_we     = 1'b0;
            pc_write  = 1'b0;
        end

        instret_d = dbg_instret_wr ? dbg_instret_wdata : instret_q + {31'd0, pc_write};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with TIMEOUT=4: instruction sequencing, latency,
// timeouts, illegal decode, reset abort and retire-counter wrap.
module tb_core_ctrl;
    import ctrl_pkg::*;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_IMEM = 7'b1000000;
    localparam logic [6:0] S_DREQ = 7'b0100000;
    localparam logic [6:0] S_DWE  = 7'b0010000;
    localparam logic [6:0] S_IR   = 7'b0001000;
    localparam logic [6:0] S_MDR  = 7'b0000100;
    localparam logic [6:0] S_RF   = 7'b0000010;
    localparam logic [6:0] S_PC   = 7'b0000001;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        imem_valid, dmem_ready, br_taken;
    logic        imem_req, dmem_req, dmem_we, ir_write, mdr_write, rf_we, pc_write;
    logic        alu_a_sel, alu_b_sel;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic        trap;
    logic [31:0] instret;
    logic        dbg_instret_wr;
    logic [31:0] dbg_instret_wdata;
    ctrl_state_e dbg_state;
    logic [6:0]  strb;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          t0;
    logic [31:0] exp_instret;

    core_ctrl #(.TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .imem_valid(imem_valid), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .mdr_write(mdr_write), .rf_we(rf_we), .pc_write(pc_write),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .pc_sel(pc_sel), .wb_sel(wb_sel),
        .trap(trap), .trap_cause(trap_cause), .instret(instret),
        .dbg_instret_wr(dbg_instret_wr), .dbg_instret_wdata(dbg_instret_wdata),
        .dbg_state(dbg_state)
    );

    assign strb = {imem_req, dmem_req, dmem_we, ir_write, mdr_write, rf_we, pc_write};

    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cyc(input string tag, input ctrl_state_e st, input logic [6:0] s);
        check({tag, ".state"}, 32'(dbg_state), 32'(st));
        check({tag, ".strb"}, 32'(strb), 32'(s));
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(negedge clock); #1;
        check_cyc({tag, ".rst"}, ST_IDLE, S_NONE);
        check({tag, ".trap"}, 32'(trap), 32'd0);
        check({tag, ".cause"}, 32'(trap_cause), 32'd0);
        check({tag, ".instret"}, instret, 32'd0);
        exp_instret = 32'd0;
        reset_n = 1'b1;
        #1 check_cyc({tag, ".idle"}, ST_IDLE, S_NONE);
        @(negedge clock); #1;
        check_cyc({tag, ".fetch"}, ST_FETCH, S_IMEM);
    endtask

    task automatic run_simple(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic a_sel, input logic b_sel,
                              input logic [1:0] exp_pc, input logic [1:0] exp_wb);
        opcode = op; funct3 = f3; imem_valid = 1'b1; t0 = cyc_cnt;
        #1 check_cyc({tag, ".f"}, ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc({tag, ".d"}, ST_DECODE, S_NONE);
        @(negedge clock); #1;
        check_cyc({tag, ".e"}, ST_EXEC, S_NONE);
        check({tag, ".alu_a"}, 32'(alu_a_sel), 32'(a_sel));
        check({tag, ".alu_b"}, 32'(alu_b_sel), 32'(b_sel));
        @(negedge clock); #1;
        check_cyc({tag, ".wb"}, ST_WB, S_RF | S_PC);
        check({tag, ".pc_sel"}, 32'(pc_sel), 32'(exp_pc));
        check({tag, ".wb_sel"}, 32'(wb_sel), 32'(exp_wb));
        exp_instret = exp_instret + 32'd1;
        @(negedge clock); #1;
        check_cyc({tag, ".next"}, ST_FETCH, S_IMEM);
        check({tag, ".cpi"}, 32'(cyc_cnt - t0), 32'd4);
        check({tag, ".instret"}, instret, exp_instret);
    endtask

    task automatic run_branch(input string tag, input logic taken);
        opcode = OP_BRANCH; funct3 = 3'd0; imem_valid = 1'b1; t0 = cyc_cnt;
        #1 check_cyc({tag, ".f"}, ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc({tag, ".d"}, ST_DECODE, S_NONE);
        @(negedge clock); br_taken = taken;
        #1 check_cyc({tag, ".e"}, ST_EXEC, S_PC);
        check({tag, ".pc_sel"}, 32'(pc_sel), taken ? 32'd1 : 32'd0);
        check({tag, ".alu_b"}, 32'(alu_b_sel), 32'd0);
        exp_instret = exp_instret + 32'd1;
        @(negedge clock); br_taken = 1'b0;
        #1 check_cyc({tag, ".next"}, ST_FETCH, S_IMEM);
        check({tag, ".cpi"}, 32'(cyc_cnt - t0), 32'd3);
        check({tag, ".instret"}, instret, exp_instret);
    endtask

    task automatic run_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3);
        opcode = op; funct3 = f3; imem_valid = 1'b1;
        #1 check_cyc({tag, ".f"}, ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc({tag, ".d"}, ST_DECODE, S_NONE);
        @(negedge clock); #1;
        check_cyc({tag, ".t"}, ST_TRAP, S_NONE);
        check({tag, ".trap"}, 32'(trap), 32'd1);
        check({tag, ".cause"}, 32'(trap_cause), 32'(CAUSE_ILLEGAL));
        imem_valid = 1'b1; dmem_ready = 1'b1; br_taken = 1'b1;
        @(negedge clock); #1;
        check_cyc({tag, ".hold"}, ST_TRAP, S_NONE);
        check({tag, ".cause2"}, 32'(trap_cause), 32'(CAUSE_ILLEGAL));
        imem_valid = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    endtask

    // Brings a store from FETCH up to its first MEM cycle with dmem_ready low.
    task automatic store_to_mem(input string tag);
        opcode = OP_STORE; funct3 = 3'd2; imem_valid = 1'b1; t0 = cyc_cnt;
        #1 check_cyc({tag, ".f"}, ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc({tag, ".d"}, ST_DECODE, S_NONE);
        @(negedge clock); #1;
        check_cyc({tag, ".e"}, ST_EXEC, S_NONE);
        check({tag, ".alu_b"}, 32'(alu_b_sel), 32'd1);
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; opcode = '0; funct3 = '0;
        imem_valid = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
        dbg_instret_wr = 1'b0; dbg_instret_wdata = '0; exp_instret = '0;

        do_reset("por");
        run_simple("add", OP_R, 3'd0, 1'b0, 1'b0, PC_SEL_PLUS4, WB_SEL_ALU);

        // Load with three wait cycles before dmem_ready.
        opcode = OP_LOAD; funct3 = 3'd2; imem_valid = 1'b1; t0 = cyc_cnt;
        #1 check_cyc("ld.f", ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc("ld.d", ST_DECODE, S_NONE);
        @(negedge clock); #1;
        check_cyc("ld.e", ST_EXEC, S_NONE);
        check("ld.alu_b", 32'(alu_b_sel), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check_cyc("ld.wait", ST_MEM, S_DREQ);
        end
        @(negedge clock); dmem_ready = 1'b1;
        #1 check_cyc("ld.rdy", ST_MEM, S_DREQ | S_MDR);
        @(negedge clock); dmem_ready = 1'b0;
        #1 check_cyc("ld.wb", ST_WB, S_RF | S_PC);
        check("ld.wb_sel", 32'(wb_sel), 32'(WB_SEL_MDR));
        exp_instret = exp_instret + 32'd1;
        @(negedge clock); #1;
        check_cyc("ld.next", ST_FETCH, S_IMEM);
        check("ld.cpi", 32'(cyc_cnt - t0), 32'd8);
        check("ld.instret", instret, exp_instret);

        run_branch("beq_t", 1'b1);
        run_branch("beq_n", 1'b0);
        run_simple("addi",  OP_IMM,   3'd0, 1'b0, 1'b1, PC_SEL_PLUS4, WB_SEL_ALU);
        run_simple("jal",   OP_JAL,   3'd0, 1'b0, 1'b1, PC_SEL_IMM,   WB_SEL_LINK);
        run_simple("jalr",  OP_JALR,  3'd0, 1'b0, 1'b1, PC_SEL_JALR,  WB_SEL_LINK);
        run_simple("lui",   OP_LUI,   3'd0, 1'b0, 1'b1, PC_SEL_PLUS4, WB_SEL_IMM);
        run_simple("auipc", OP_AUIPC, 3'd0, 1'b1, 1'b1, PC_SEL_PLUS4, WB_SEL_ALU);

        // Zero-wait store retires from MEM.
        store_to_mem("st");
        dmem_ready = 1'b1;
        #1 check_cyc("st.m", ST_MEM, S_DREQ | S_DWE | S_PC);
        check("st.pc_sel", 32'(pc_sel), 32'(PC_SEL_PLUS4));
        exp_instret = exp_instret + 32'd1;
        @(negedge clock); dmem_ready = 1'b0;
        #1 check_cyc("st.next", ST_FETCH, S_IMEM);
        check("st.cpi", 32'(cyc_cnt - t0), 32'd4);
        check("st.instret", instret, exp_instret);

        // Fetch near-miss: imem_valid arrives on the 4th FETCH cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            check_cyc("nm.wait", ST_FETCH, S_IMEM);
        end
        @(negedge clock); opcode = OP_R; funct3 = 3'd0; imem_valid = 1'b1;
        #1 check_cyc("nm.f4", ST_FETCH, S_IMEM | S_IR);
        @(negedge clock); imem_valid = 1'b0;
        #1 check_cyc("nm.d", ST_DECODE, S_NONE);
        check("nm.trap", 32'(trap), 32'd0);
        @(negedge clock);
        @(negedge clock);
        exp_instret = exp_instret + 32'd1;
        @(negedge clock); #1;
        check_cyc("nm.next", ST_FETCH, S_IMEM);
        check("nm.instret", instret, exp_instret);

        // Fetch timeout: 4 FETCH cycles with no imem_valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check_cyc("ito.wait", ST_FETCH, S_IMEM);
        end
        @(negedge clock); #1;
        check_cyc("ito.t", ST_TRAP, S_NONE);
        check("ito.trap", 32'(trap), 32'd1);
        check("ito.cause", 32'(trap_cause), 32'(CAUSE_IMEM));
        imem_valid = 1'b1; dmem_ready = 1'b1;
        @(negedge clock); #1;
        check_cyc("ito.hold", ST_TRAP, S_NONE);
        check("ito.instret", instret, exp_instret);
        imem_valid = 1'b0; dmem_ready = 1'b0;
        do_reset("rst1");

        run_illegal("ill7f", 7'b1111111, 3'd0);
        do_reset("rst2");
        run_illegal("ldf3", OP_LOAD, 3'd3);
        do_reset("rst3");

        // Data-memory timeout on a store.
        store_to_mem("dto");
        for (int i = 0; i < 4; i++) begin
            #1 check_cyc("dto.wait", ST_MEM, S_DREQ | S_DWE);
            @(negedge clock);
        end
        #1 check_cyc("dto.t", ST_TRAP, S_NONE);
        check("dto.cause", 32'(trap_cause), 32'(CAUSE_DMEM));
        check("dto.instret", instret, 32'd0);
        do_reset("rst4");

        // Reset asserted while a store waits in MEM.
        run_simple("add2", OP_R, 3'd0, 1'b0, 1'b0, PC_SEL_PLUS4, WB_SEL_ALU);
        store_to_mem("sta");
        #1 check_cyc("sta.m", ST_MEM, S_DREQ | S_DWE);
        @(negedge clock); reset_n = 1'b0; dmem_ready = 1'b1;
        #1 check("sta.rst_strb", 32'(strb), 32'(S_NONE));
        @(negedge clock); dmem_ready = 1'b0;
        #1 check_cyc("sta.idle", ST_IDLE, S_NONE);
        check("sta.instret", instret, 32'd0);
        exp_instret = 32'd0;
        reset_n = 1'b1;
        @(negedge clock); #1;
        check_cyc("sta.fetch", ST_FETCH, S_IMEM);

        // Retire counter wrap.
        dbg_instret_wr = 1'b1; dbg_instret_wdata = 32'hFFFF_FFFF;
        @(negedge clock); dbg_instret_wr = 1'b0;
        #1 check("wrap.preset", instret, 32'hFFFF_FFFF);
        exp_instret = 32'hFFFF_FFFF;
        run_simple("wrap", OP_R, 3'd0, 1'b0, 1'b0, PC_SEL_PLUS4, WB_SEL_ALU);
        check("wrap.zero", instret, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
